// File: rtl/rom_scan_engine.sv
// ROM range scanner: reads a programmable address window of a synchronous-read ROM,
// streams (address, data) over valid/ready and sums the data. Optional ROM_SCAN_COMPARE_EN adds exp_sum/match.
`timescale 1ns/1ps
module rom_scan_engine #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1,
  parameter int SUM_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  checksum
`ifdef ROM_SCAN_COMPARE_EN
  ,
  input  logic [SUM_W-1:0]  exp_sum,
  output logic              match
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, PRESENT, DONE} state_t;

  localparam logic [2:0]      LAT_INIT = 3'(ROM_LAT);
  localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W+1)'(1);

  state_t            state, next_state;
  logic [ADDR_W:0]   remaining;
  logic [2:0]        lat_cnt;
  logic              last_word;
  logic [SUM_W-1:0]  next_sum;

  assign last_word = (remaining == ONE_WORD);
  assign next_sum  = checksum + SUM_W'(out_data);
  assign out_valid = (state == PRESENT);
  assign busy      = (state == WAIT) || (state == PRESENT);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = (count == '0) ? DONE : WAIT;
      end
      WAIT: begin
        if (lat_cnt == 3'd0) next_state = PRESENT;
      end
      PRESENT: begin
        if (out_ready) next_state = last_word ? DONE : WAIT;
      end
      default: next_state = IDLE;
    endcase
  end

  // The latency counter reaching zero marks the edge where rom_q belongs to rom_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      checksum  <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            checksum <= '0;
            if (count != '0) begin
              rom_addr  <= start_addr;
              remaining <= count;
              lat_cnt   <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 3'd0) begin
            out_data <= rom_q;
            out_addr <= rom_addr;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            checksum  <= next_sum;
            remaining <= remaining - ONE_WORD;
            if (!last_word) begin
              rom_addr <= rom_addr + ADDR_W'(1);
              lat_cnt  <= LAT_INIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ROM_SCAN_COMPARE_EN
  // A zero-length scan enters DONE with a final sum of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match <= 1'b0;
    end else if ((state == IDLE || state == DONE) && start) begin
      match <= (count == '0) ? (exp_sum == '0) : 1'b0;
    end else if (state == PRESENT && out_ready && last_word) begin
      match <= (next_sum == exp_sum);
    end
  end
`endif

endmodule

// File: tb/tb_rom_scan_engine.sv
// Scoreboard bench for rom_scan_engine: instance A (ROM_LAT=1) and instance B (ROM_LAT=3).
`timescale 1ns/1ps
module tb_rom_scan_engine;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_start = 1'b0, b_start = 1'b0;
  logic [13:0] a_start_addr = '0, b_start_addr = '0;
  logic [14:0] a_count = '0, b_count = '0;
  logic [13:0] a_rom_addr, b_rom_addr, a_out_addr, b_out_addr;
  logic [7:0]  a_rom_q, b_rom_q, a_out_data, b_out_data;
  logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic        a_ready = 1'b0, b_ready = 1'b0;
  logic [15:0] a_sum, b_sum;
`ifdef ROM_SCAN_COMPARE_EN
  logic [15:0] a_exp_sum = '0, b_exp_sum = '0;
  logic        a_match, b_match;
`endif

  word_t a_exp[$], b_exp[$];
  int    a_hs[$], b_hs[$];

  rom_scan_engine #(.ADDR_W(14), .DATA_W(8), .ROM_LAT(1), .SUM_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .start_addr(a_start_addr), .count(a_count),
    .rom_addr(a_rom_addr), .rom_q(a_rom_q), .out_valid(a_valid), .out_ready(a_ready),
    .out_addr(a_out_addr), .out_data(a_out_data), .busy(a_busy), .done(a_done), .checksum(a_sum)
`ifdef ROM_SCAN_COMPARE_EN
    , .exp_sum(a_exp_sum), .match(a_match)
`endif
  );

  rom_scan_engine #(.ADDR_W(14), .DATA_W(8), .ROM_LAT(3), .SUM_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .start_addr(b_start_addr), .count(b_count),
    .rom_addr(b_rom_addr), .rom_q(b_rom_q), .out_valid(b_valid), .out_ready(b_ready),
    .out_addr(b_out_addr), .out_data(b_out_data), .busy(b_busy), .done(b_done), .checksum(b_sum)
`ifdef ROM_SCAN_COMPARE_EN
    , .exp_sum(b_exp_sum), .match(b_match)
`endif
  );

  // ROM models: q = addr[7:0], with one and three clocks of read latency.
  logic [7:0] b_pipe [3];
  always @(posedge clk) a_rom_q <= a_rom_addr[7:0];
  always @(posedge clk) begin
    b_pipe[0] <= b_rom_addr[7:0];
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_rom_q = b_pipe[2];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitors pop one expected word per handshake and watch for stability while stalled.
  logic        a_hold = 1'b0, b_hold = 1'b0;
  logic [13:0] a_prev_addr, b_prev_addr;
  logic [7:0]  a_prev_data, b_prev_data;
  word_t       a_w, b_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_hold = 1'b0;
    end else if (a_valid) begin
      if (a_hold) begin
        check_output("A hold addr", 32'(a_out_addr), 32'(a_prev_addr));
        check_output("A hold data", 32'(a_out_data), 32'(a_prev_data));
      end
      if (a_ready) begin
        a_hold = 1'b0;
        checks++;
        if (a_exp.size() == 0) begin
          errors++;
          $display("[TB] FAIL A unexpected word: got addr 0x%0h data 0x%0h, expected none", a_out_addr, a_out_data);
        end else begin
          a_w = a_exp.pop_front();
          check_output("A word addr", 32'(a_out_addr), 32'(a_w.addr));
          check_output("A word data", 32'(a_out_data), 32'(a_w.data));
          a_hs.push_back(cyc);
        end
      end else begin
        a_hold = 1'b1;
        a_prev_addr = a_out_addr;
        a_prev_data = a_out_data;
      end
    end else begin
      a_hold = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_hold = 1'b0;
    end else if (b_valid) begin
      if (b_hold) begin
        check_output("B hold addr", 32'(b_out_addr), 32'(b_prev_addr));
        check_output("B hold data", 32'(b_out_data), 32'(b_prev_data));
      end
      if (b_ready) begin
        b_hold = 1'b0;
        checks++;
        if (b_exp.size() == 0) begin
          errors++;
          $display("[TB] FAIL B unexpected word: got addr 0x%0h data 0x%0h, expected none", b_out_addr, b_out_data);
        end else begin
          b_w = b_exp.pop_front();
          check_output("B word addr", 32'(b_out_addr), 32'(b_w.addr));
          check_output("B word data", 32'(b_out_data), 32'(b_w.data));
          b_hs.push_back(cyc);
        end
      end else begin
        b_hold = 1'b1;
        b_prev_addr = b_out_addr;
        b_prev_data = b_out_data;
      end
    end else begin
      b_hold = 1'b0;
    end
  end

  // Pulses start for one edge and queues the expected words of the scan.
  task automatic apply_stimulus(input bit on_b, input logic [13:0] addr, input logic [14:0] cnt);
    word_t w;
    for (int i = 0; i < int'(cnt); i++) begin
      w.addr = addr + 14'(i);
      w.data = w.addr[7:0];
      if (on_b) b_exp.push_back(w);
      else      a_exp.push_back(w);
    end
    @(posedge clk); #1;
    if (on_b) begin b_start = 1'b1; b_start_addr = addr; b_count = cnt; end
    else      begin a_start = 1'b1; a_start_addr = addr; a_count = cnt; end
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic wait_done(input bit on_b, input int budget);
    int n = 0;
    while (!(on_b ? b_done : a_done) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_output(on_b ? "B done" : "A done", 32'(on_b ? b_done : a_done), 32'd1);
    check_output(on_b ? "B busy at done" : "A busy at done", 32'(on_b ? b_busy : a_busy), 32'd0);
    check_output(on_b ? "B queue drained" : "A queue drained",
                 32'(on_b ? b_exp.size() : a_exp.size()), 32'd0);
  endtask

  task automatic check_period(input bit on_b, input int period);
    int n = on_b ? b_hs.size() : a_hs.size();
    for (int i = 1; i < n; i++) begin
      if (on_b) check_output("B word period", 32'(b_hs[i] - b_hs[i-1]), 32'(period));
      else      check_output("A word period", 32'(a_hs[i] - a_hs[i-1]), 32'(period));
    end
  endtask

  initial begin
    #23;
    check_output("reset rom_addr", 32'(a_rom_addr), 32'd0);
    check_output("reset out_addr", 32'(a_out_addr), 32'd0);
    check_output("reset out_data", 32'(a_out_data), 32'd0);
    check_output("reset out_valid", 32'(a_valid), 32'd0);
    check_output("reset busy", 32'(a_busy), 32'd0);
    check_output("reset done", 32'(a_done), 32'd0);
    check_output("reset checksum", 32'(a_sum), 32'd0);
    rst_n = 1'b1;

    $display("[TB] basic scan, ROM_LAT=1");
    a_ready = 1'b1;
    a_hs.delete();
    apply_stimulus(1'b0, 14'h0000, 15'd10);
    wait_done(1'b0, 100);
    check_output("A basic checksum", 32'(a_sum), 32'h002D);
    check_output("A basic word count", 32'(a_hs.size()), 32'd10);
    check_period(1'b0, 3);

    $display("[TB] backpressure scan with ignored mid-scan start");
    apply_stimulus(1'b0, 14'h0000, 15'd10);
    for (int k = 0; k < 400 && !a_done; k++) begin
      @(posedge clk); #1;
      a_ready = 1'($urandom_range(0, 1));
      a_start = (k == 6);
      if (k == 6) begin a_start_addr = 14'h0100; a_count = 15'd2; end
    end
    a_start = 1'b0;
    a_ready = 1'b1;
    wait_done(1'b0, 10);
    check_output("A backpressure checksum", 32'(a_sum), 32'h002D);

    $display("[TB] wrap scan");
    apply_stimulus(1'b0, 14'h3FFE, 15'd4);
    wait_done(1'b0, 100);
    check_output("A wrap checksum", 32'(a_sum), 32'h01FE);
    check_output("A wrap last rom_addr", 32'(a_rom_addr), 32'h0001);

    $display("[TB] zero count");
`ifdef ROM_SCAN_COMPARE_EN
    a_exp_sum = 16'h0000;
`endif
    apply_stimulus(1'b0, 14'h0040, 15'd0);
    check_output("A zero done", 32'(a_done), 32'd1);
    check_output("A zero checksum", 32'(a_sum), 32'd0);
    check_output("A zero out_valid", 32'(a_valid), 32'd0);
    check_output("A zero busy", 32'(a_busy), 32'd0);
`ifdef ROM_SCAN_COMPARE_EN
    check_output("A zero match", 32'(a_match), 32'd1);
`endif

    $display("[TB] reset mid-scan");
    a_hs.delete();
    apply_stimulus(1'b0, 14'h0005, 15'd10);
    for (int k = 0; k < 50 && a_hs.size() < 2; k++) @(negedge clk);
    @(posedge clk); #1;
    a_ready = 1'b0;
    for (int k = 0; k < 20 && !a_valid; k++) begin @(posedge clk); #1; end
    check_output("A stalled out_valid", 32'(a_valid), 32'd1);
    check_output("A partial checksum", 32'(a_sum), 32'd11);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("A async reset out_valid", 32'(a_valid), 32'd0);
    check_output("A async reset busy", 32'(a_busy), 32'd0);
    check_output("A async reset done", 32'(a_done), 32'd0);
    check_output("A async reset checksum", 32'(a_sum), 32'd0);
    a_exp.delete();
    #10;
    rst_n = 1'b1;
    a_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("A after release out_valid", 32'(a_valid), 32'd0);
    check_output("A after release busy", 32'(a_busy), 32'd0);
    apply_stimulus(1'b0, 14'h0000, 15'd10);
    wait_done(1'b0, 100);
    check_output("A rescan checksum", 32'(a_sum), 32'h002D);

    $display("[TB] ROM_LAT=3 scan");
    b_ready = 1'b1;
    b_hs.delete();
`ifdef ROM_SCAN_COMPARE_EN
    b_exp_sum = 16'h0078;
`endif
    apply_stimulus(1'b1, 14'h0000, 15'd16);
    wait_done(1'b1, 200);
    check_output("B checksum", 32'(b_sum), 32'h0078);
    check_output("B word count", 32'(b_hs.size()), 32'd16);
    check_period(1'b1, 5);
`ifdef ROM_SCAN_COMPARE_EN
    check_output("B match equal", 32'(b_match), 32'd1);
    b_exp_sum = 16'h0077;
    apply_stimulus(1'b1, 14'h0000, 15'd16);
    check_output("B match cleared on start", 32'(b_match), 32'd0);
    wait_done(1'b1, 200);
    check_output("B checksum again", 32'(b_sum), 32'h0078);
    check_output("B match unequal", 32'(b_match), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
